hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destinations over NSTAGES post-decode stages and
// produces the decode stall, registered EX bypass selects, flush bubbles and perf counters.
module hazard_scoreboard #(
  parameter int unsigned REGBITS    = 5,
  parameter int unsigned NSTAGES    = 3,
  parameter int unsigned ALU_READY  = 1,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNTW       = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               id_valid,
  input  logic [REGBITS-1:0]                 id_rs,
  input  logic [REGBITS-1:0]                 id_rt,
  input  logic                               id_uses_rs,
  input  logic                               id_uses_rt,
  input  logic [REGBITS-1:0]                 id_wa,
  input  logic                               id_regwrite,
  input  logic                               id_is_load,
  input  logic                               flush,
  output logic                               stall,
  output logic [$clog2(NSTAGES+1)-1:0]       ex_fwd_a,
  output logic [$clog2(NSTAGES+1)-1:0]       ex_fwd_b,
  output logic                               ex_valid,
  output logic [CNTW-1:0]                    stall_cnt,
  output logic [CNTW-1:0]                    fwd_cnt
);

  localparam int unsigned FW = $clog2(NSTAGES + 1);

  logic               valid_q    [1:NSTAGES];
  logic               valid_d    [1:NSTAGES];
  logic [REGBITS-1:0] wa_q       [1:NSTAGES];
  logic [REGBITS-1:0] wa_d       [1:NSTAGES];
  logic               regwrite_q [1:NSTAGES];
  logic               regwrite_d [1:NSTAGES];
  logic               is_load_q  [1:NSTAGES];
  logic               is_load_d  [1:NSTAGES];

  logic [FW-1:0]   ex_fwd_a_q, ex_fwd_a_d;
  logic [FW-1:0]   ex_fwd_b_q, ex_fwd_b_d;
  logic            ex_valid_q, ex_valid_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] fwd_cnt_q, fwd_cnt_d;

  logic [FW-1:0] sel_a, sel_b;
  logic          haz_a, haz_b;
  logic          bubble;

  function automatic logic live(input int unsigned k);
    return valid_q[k] && regwrite_q[k] && (wa_q[k] != '0);
  endfunction

  function automatic int unsigned ready_at(input int unsigned k);
    return is_load_q[k] ? LOAD_READY : ALU_READY;
  endfunction

  // Scan oldest to youngest so the youngest matching producer overrides; WB stage excluded.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int unsigned k = NSTAGES - 1; k >= 1; k--) begin
      if (id_valid && id_uses_rs && live(k) && (wa_q[k] == id_rs)) begin
        haz_a = !(k + 1 > ready_at(k));
        sel_a = haz_a ? '0 : FW'(k + 1);
      end
      if (id_valid && id_uses_rt && live(k) && (wa_q[k] == id_rt)) begin
        haz_b = !(k + 1 > ready_at(k));
        sel_b = haz_b ? '0 : FW'(k + 1);
      end
    end
  end

  assign stall  = (haz_a || haz_b) && !flush && !reset;
  assign bubble = flush || stall;

  always_comb begin
    valid_d    = valid_q;
    wa_d       = wa_q;
    regwrite_d = regwrite_q;
    is_load_d  = is_load_q;
    for (int unsigned k = 2; k <= NSTAGES; k++) begin
      valid_d[k]    = valid_q[k-1];
      wa_d[k]       = wa_q[k-1];
      regwrite_d[k] = regwrite_q[k-1];
      is_load_d[k]  = is_load_q[k-1];
    end
    if (flush) begin
      valid_d[2] = 1'b0;
    end
    if (bubble) begin
      valid_d[1]    = 1'b0;
      wa_d[1]       = '0;
      regwrite_d[1] = 1'b0;
      is_load_d[1]  = 1'b0;
    end else begin
      valid_d[1]    = id_valid;
      wa_d[1]       = id_wa;
      regwrite_d[1] = id_regwrite;
      is_load_d[1]  = id_is_load;
    end

    ex_fwd_a_d = bubble ? '0 : sel_a;
    ex_fwd_b_d = bubble ? '0 : sel_b;
    ex_valid_d = valid_d[1];

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
    fwd_cnt_d = fwd_cnt_q;
    if (!bubble && id_valid && ((sel_a != '0) || (sel_b != '0)) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= NSTAGES; k++) begin
        valid_q[k]    <= 1'b0;
        wa_q[k]       <= '0;
        regwrite_q[k] <= 1'b0;
        is_load_q[k]  <= 1'b0;
      end
      ex_fwd_a_q  <= '0;
      ex_fwd_b_q  <= '0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      wa_q        <= wa_d;
      regwrite_q  <= regwrite_d;
      is_load_q   <= is_load_d;
      ex_fwd_a_q  <= ex_fwd_a_d;
      ex_fwd_b_q  <= ex_fwd_b_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign ex_fwd_a  = ex_fwd_a_q;
  assign ex_fwd_b  = ex_fwd_b_q;
  assign ex_valid  = ex_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (EX/MEM/WB, load ready at MEM).
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_wa;
  logic       id_regwrite;
  logic       id_is_load;
  logic       flush;
  logic       stall;
  logic [1:0] ex_fwd_a;
  logic [1:0] ex_fwd_b;
  logic       ex_valid;
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;

  int unsigned tests;
  int unsigned failed;

  hazard_scoreboard #(
    .REGBITS(5), .NSTAGES(3), .ALU_READY(1), .LOAD_READY(2), .CNTW(32)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wa(id_wa),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_valid(ex_valid),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] wa, input logic rw, input logic ld);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_wa = wa; id_regwrite = rw; id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  // lw $8 into ID
  task automatic issue_lw8();
    set_id(1'b1, 5'd29, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    flush = 1'b0;
    reset = 1'b1;

    // Reset held with hazard-looking inputs
    issue_lw8();
    step();
    set_id(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1);
    check("rst_stall", stall, 0);
    step();
    check("rst_stall2", stall, 0);
    idle();
    reset = 1'b0;
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_fwd_a", ex_fwd_a, 0);
    check("rst_fwd_b", ex_fwd_b, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_fwd_cnt", fwd_cnt, 0);
    step();

    // add $3 ; add $4,$3,$5 -> EX/MEM bypass on A
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    check("alu_stall", stall, 0);
    step();
    check("alu_fwd_a", ex_fwd_a, 2);
    check("alu_fwd_b", ex_fwd_b, 0);
    check("alu_ex_valid", ex_valid, 1);
    check("alu_fwd_cnt", fwd_cnt, 1);
    drain();

    // lw $8 ; add $9,$2,$8 -> one stall, then MEM/WB bypass on B
    issue_lw8();
    step();
    set_id(1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    check("lu_stall1", stall, 1);
    step();
    check("lu_bubble", ex_valid, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_stall2", stall, 0);
    step();
    check("lu_fwd_b", ex_fwd_b, 3);
    check("lu_fwd_a", ex_fwd_a, 0);
    check("lu_ex_valid", ex_valid, 1);
    check("lu_fwd_cnt", fwd_cnt, 2);
    check("lu_stall_cnt2", stall_cnt, 1);
    drain();

    // lw $8 ; unrelated ; sw reading $8 as rt
    issue_lw8();
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd29, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
    check("sw_stall", stall, 0);
    step();
    check("sw_fwd_b", ex_fwd_b, 3);
    check("sw_fwd_cnt", fwd_cnt, 3);
    drain();

    // Writes to $0 never hazard or forward
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
    check("r0_stall", stall, 0);
    step();
    check("r0_fwd_a", ex_fwd_a, 0);
    check("r0_fwd_b", ex_fwd_b, 0);
    check("r0_ex_valid", ex_valid, 1);
    set_id(1'b1, 5'd29, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
    check("r0_lw_stall", stall, 0);
    drain();

    // Flush in the would-be stall cycle wins and kills the load in flight
    issue_lw8();
    step();
    set_id(1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_stall", stall, 0);
    step();
    flush = 1'b0;
    #1;
    check("fl_ex_valid", ex_valid, 0);
    check("fl_stall_cnt", stall_cnt, 1);
    check("fl_stall_after", stall, 0);
    step();
    check("fl_stage2_dead", ex_fwd_b, 0);
    check("fl_ex_valid2", ex_valid, 1);
    drain();

    // Youngest producer wins
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd13, 1'b1, 1'b0);
    step();
    check("yw_fwd_a", ex_fwd_a, 2);
    check("yw_fwd_b", ex_fwd_b, 2);
    check("yw_fwd_cnt", fwd_cnt, 4);
    drain();

    // Producer already in WB is served by the register file
    issue_lw8();
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd15, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
    check("wb_stall", stall, 0);
    step();
    check("wb_fwd_a", ex_fwd_a, 0);
    check("wb_fwd_cnt", fwd_cnt, 4);
    drain();

    // id_valid = 0 never stalls and yields an EX bubble
    issue_lw8();
    step();
    set_id(1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    check("iv_stall", stall, 0);
    step();
    check("iv_ex_valid", ex_valid, 0);
    check("iv_stall_cnt", stall_cnt, 1);
    drain();

    // Mid-operation reset discards the in-flight load
    issue_lw8();
    step();
    set_id(1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("mr_stall", stall, 0);
    step();
    reset = 1'b0;
    #1;
    check("mr_ex_valid", ex_valid, 0);
    check("mr_stall_cnt", stall_cnt, 0);
    check("mr_fwd_cnt", fwd_cnt, 0);
    check("mr_stall_after", stall, 0);
    step();
    check("mr_fwd_b", ex_fwd_b, 0);
    check("mr_ex_valid2", ex_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
